// File: rtl/mem_stage.sv
// Data-memory stage: byte/half/word loads and stores against a little-endian word array,
// with WAIT_CYCLES wait states per access. Optional misalignment rejection: DMEM_MISALIGN_CHECK_EN.
module mem_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemBusy,
    output logic        MisAlign,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // Handshake: a request is taken only when MemReq is high in IDLE (inputs sampled at that
    // edge); MemReady is a one-cycle pulse that carries ReadData/MisAlign, after which IDLE returns.
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            accept;
    logic            mis_req;
    logic            wr_q, sgn_q, mis_q;
    logic [1:0]      size_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     load_val;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic            unused_addr;

    assign unused_addr = ^Addr[31:AW+2];

    always_comb begin
        mis_req = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        case (MemSize)
            2'b00:   mis_req = 1'b0;
            2'b01:   mis_req = Addr[0];
            default: mis_req = |Addr[1:0];
        endcase
`endif
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (MemReq) begin
                    accept = 1'b1;
                    if (mis_req) begin
                        state_nxt = DONE;
                    end else if (WAIT_CYCLES == 0) begin
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Forced alignment: narrow lane selection ignores the low bits a wider access does not use.
    assign word_idx = addr_q[AW+1:2];
    assign lane     = addr_q[1:0];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{lane, 3'b000} +: 8];
    assign rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        be       = 4'b1111;
        wd       = wdata_q;
        case (size_q)
            2'b00: begin
                load_val = {{24{sgn_q & rd_byte[7]}}, rd_byte};
                be       = 4'b0001 << lane;
                wd       = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                load_val = {{16{sgn_q & rd_half[15]}}, rd_half};
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wd       = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // The array has no reset; a store is only committed at its ACCESS edge.
    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            wr_q     <= 1'b0;
            sgn_q    <= 1'b0;
            mis_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            ReadData <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                wr_q    <= MemWrite;
                sgn_q   <= MemSigned;
                size_q  <= MemSize;
                addr_q  <= Addr[AW+1:0];
                wdata_q <= WriteData;
                mis_q   <= mis_req;
                if (mis_req) ReadData <= 32'd0;
            end
            if (state == ACCESS) ReadData <= wr_q ? 32'd0 : load_val;
        end
    end

    assign MemReady  = (state == DONE);
    assign MemBusy   = (state == WAIT) || (state == ACCESS);
    assign MisAlign  = mis_q && (state == DONE);
    assign dbg_state = state;

endmodule
